// File: rtl/capture_sequencer_if.sv
// RAM write-port bundle for the capture sequencer: probe samples in, RAM writes out.
interface capture_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int CH     = 3
);
    logic              sample_en;
    logic [CH-1:0]     probe;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CH-1:0]     wr_data;

    // Sequencer side: consumes samples, drives the RAM write port.
    modport master (
        input  sample_en, probe,
        output wr_en, wr_addr, wr_data
    );

    // Probe / RAM side.
    modport slave (
        output sample_en, probe,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/capture_sequencer.sv
// Triggered logic-analyser capture into a circular display RAM:
// pre-trigger fill, masked level/edge trigger wait, post-trigger fill, frozen hold.
// PRE_SAMPLES must lie in 1..DEPTH-1; HOLD_FRAMES must be at least 1.
module capture_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int CH          = 3,
    parameter int PRE_SAMPLES = 1024,
    parameter int HOLD_FRAMES = 2
) (
    input  logic                clock,
    input  logic                reset,
    capture_sequencer_if.master bus,
    input  logic                arm,
    input  logic                abort,
    input  logic                auto_rearm,
    input  logic [CH-1:0]       trig_mask,
    input  logic [CH-1:0]       trig_value,
    input  logic                trig_rise,
    input  logic                frame_start,
    output logic                busy,
    output logic                triggered,
    output logic                done,
    output logic [ADDR_W-1:0]   base_addr,
    output logic [2:0]          state
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int POST_N = DEPTH - PRE_SAMPLES - 1;
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_SAMPLES - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'((POST_N > 0) ? POST_N - 1 : 0);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_SAMPLES);
    localparam int FR_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(HOLD_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t            state_q, state_nx;
    logic [ADDR_W-1:0] ptr_q, cnt_q, trig_addr_q;
    logic [FR_W-1:0]   frame_q;
    logic              prev_match_q;
    logic              match, hit;
    logic              smp, start, fire, to_hold, frame_inc;

    assign match = ((bus.probe ^ trig_value) & trig_mask) == '0;
    assign hit   = trig_rise ? (match && !prev_match_q) : match;
    assign state = state_q;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_nx;
    end

    // Next state and per-cycle actions; abort beats arm beats sample_en.
    always_comb begin
        state_nx  = state_q;
        smp       = 1'b0;
        start     = 1'b0;
        fire      = 1'b0;
        to_hold   = 1'b0;
        frame_inc = 1'b0;
        busy      = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (arm) begin
                    state_nx = S_PRE;
                    start    = 1'b1;
                end
                S_PRE: if (bus.sample_en) begin
                    smp = 1'b1;
                    if (cnt_q == PRE_LAST) state_nx = S_WAIT;
                end
                S_WAIT: if (bus.sample_en) begin
                    smp = 1'b1;
                    if (hit) begin
                        fire = 1'b1;
                        // With no post-trigger room the trigger sample completes the capture.
                        if (POST_N == 0) begin
                            to_hold  = 1'b1;
                            state_nx = S_HOLD;
                        end else begin
                            state_nx = S_POST;
                        end
                    end
                end
                S_POST: if (bus.sample_en) begin
                    smp = 1'b1;
                    if (cnt_q == POST_LAST) begin
                        to_hold  = 1'b1;
                        state_nx = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (arm) begin
                        state_nx = S_PRE;
                        start    = 1'b1;
                    end else if (auto_rearm && frame_start) begin
                        if (frame_q == FR_LAST) begin
                            state_nx = S_PRE;
                            start    = 1'b1;
                        end else begin
                            frame_inc = 1'b1;
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Write port, pointer, counters and capture status; later statements override earlier ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            trig_addr_q  <= '0;
            frame_q      <= '0;
            prev_match_q <= 1'b0;
            triggered    <= 1'b0;
            done         <= 1'b0;
            base_addr    <= '0;
        end else begin
            bus.wr_en <= smp;
            if (smp) begin
                bus.wr_addr  <= ptr_q;
                bus.wr_data  <= bus.probe;
                ptr_q        <= ptr_q + 1'b1;
                cnt_q        <= cnt_q + 1'b1;
                prev_match_q <= match;
            end
            if (fire) begin
                trig_addr_q <= ptr_q;
                triggered   <= 1'b1;
                cnt_q       <= '0;
            end
            if (to_hold) begin
                done      <= 1'b1;
                base_addr <= (fire ? ptr_q : trig_addr_q) - PRE_OFS;
                frame_q   <= '0;
            end
            if (frame_inc) frame_q <= frame_q + 1'b1;
            if (start) begin
                ptr_q        <= '0;
                cnt_q        <= '0;
                prev_match_q <= 1'b0;
                triggered    <= 1'b0;
                done         <= 1'b0;
            end
            if (abort) begin
                triggered <= 1'b0;
                done      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer (DEPTH=16, PRE_SAMPLES=4, HOLD_FRAMES=2).
module tb_capture_sequencer;
    localparam int ADDR_W = 4;
    localparam int CH     = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              arm, abort, auto_rearm, trig_rise, frame_start;
    logic [CH-1:0]     trig_mask, trig_value;
    logic              busy, triggered, done;
    logic [ADDR_W-1:0] base_addr;
    logic [2:0]        state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [6:0] sb[$];
    logic [6:0] e;

    capture_sequencer_if #(.ADDR_W(ADDR_W), .CH(CH)) bus ();

    capture_sequencer #(.ADDR_W(ADDR_W), .CH(CH), .PRE_SAMPLES(4), .HOLD_FRAMES(2)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .arm(arm), .abort(abort), .auto_rearm(auto_rearm),
        .trig_mask(trig_mask), .trig_value(trig_value), .trig_rise(trig_rise),
        .frame_start(frame_start),
        .busy(busy), .triggered(triggered), .done(done),
        .base_addr(base_addr), .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Every RAM write must match the oldest expected {addr,data}.
    always @(posedge clock) begin
        #1;
        if (bus.wr_en === 1'b1) begin
            if (sb.size() == 0) chk("unexp_wr", bus.wr_en, 0);
            else begin
                e = sb.pop_front();
                chk("wr", {bus.wr_addr, bus.wr_data}, e);
            end
        end
    end

    // One capture, sample_en every cycle. Sample index i goes to address i mod 16.
    // mode 0: level pattern, 1: edge pattern (001 except 000 just before trig), 2: random.
    task automatic run_cap(input int trig, input int mode, input bit do_arm,
                           input int abort_i, input int arm_i);
        int total, exp_st;
        bit aborted;
        logic [2:0] p;
        total = trig + 12;
        if (do_arm) begin
            arm = 1'b1; bus.sample_en = 1'b1; bus.probe = 3'b111;
            @(negedge clock);
            arm = 1'b0;
        end
        for (int i = 0; i < total + 3; i++) begin
            aborted = (abort_i >= 0) && (i > abort_i);
            if (aborted)        exp_st = 0;
            else if (i < 4)     exp_st = 1;
            else if (i <= trig) exp_st = 2;
            else if (i < total) exp_st = 3;
            else                exp_st = 4;
            chk("state", state, exp_st);
            chk("busy", busy, (exp_st >= 1 && exp_st <= 3));
            chk("trig", triggered, (i > trig) && !aborted);
            case (mode)
                0:       p = (i >= trig) ? 3'b001 : 3'b000;
                1:       p = (i == trig - 1) ? 3'b000 : 3'b001;
                default: p = 3'($urandom);
            endcase
            bus.probe = p; bus.sample_en = 1'b1;
            arm   = (i == arm_i);
            abort = (i == abort_i);
            if (i < total && !(abort_i >= 0 && i >= abort_i)) sb.push_back({4'(i), p});
            @(negedge clock);
        end
        bus.sample_en = 1'b0; arm = 1'b0; abort = 1'b0;
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; arm = 0; abort = 0; auto_rearm = 0; trig_rise = 0; frame_start = 0;
        trig_mask = 3'b001; trig_value = 3'b001;
        bus.sample_en = 0; bus.probe = 0;
        repeat (2) @(negedge clock);
        chk("rst_state", state, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_base", base_addr, 0);
        reset = 1'b0;
        @(negedge clock);

        // Level trigger at sample 10; stray arm in POST is ignored.
        run_cap(10, 0, 1, -1, 15);
        chk("t1_done", done, 1);
        chk("t1_base", base_addr, 6);

        // Edge trigger: held match does not fire until 000 -> 001.
        trig_rise = 1'b1;
        run_cap(9, 1, 1, -1, -1);
        chk("t2_done", done, 1);
        chk("t2_base", base_addr, 5);

        // Abort in POST with sample_en the same cycle.
        trig_rise = 1'b0; trig_mask = 3'b000;
        run_cap(4, 2, 1, 8, -1);
        chk("t4_done", done, 0);
        chk("t4_base_held", base_addr, 5);

        // Async reset mid-WAIT, between clock edges.
        trig_mask = 3'b001; trig_value = 3'b001;
        arm = 1'b1; bus.sample_en = 1'b1; bus.probe = 3'b110;
        @(negedge clock);
        arm = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.probe = 3'b110; bus.sample_en = 1'b1;
            sb.push_back({4'(i), 3'b110});
            @(negedge clock);
        end
        chk("t6_pre_state", state, 2);
        bus.sample_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t6_state", state, 0);
        chk("t6_wr_en", bus.wr_en, 0);
        chk("t6_wr_addr", bus.wr_addr, 0);
        chk("t6_wr_data", bus.wr_data, 0);
        chk("t6_busy", busy, 0);
        chk("t6_base", base_addr, 0);
        chk("t6_sb", sb.size(), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Mask 000: triggers on first WAIT sample.
        trig_mask = 3'b000;
        run_cap(4, 2, 1, -1, -1);
        chk("t3_done", done, 1);
        chk("t3_base", base_addr, 0);

        // Auto re-arm: pulse without auto_rearm is not counted, then two counted pulses.
        bus.sample_en = 1'b1; frame_start = 1'b1; auto_rearm = 1'b0;
        @(negedge clock);
        frame_start = 1'b0; auto_rearm = 1'b1;
        repeat (2) @(negedge clock);
        chk("t5_hold0", state, 4);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        chk("t5_hold1", state, 4);
        repeat (2) @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0; auto_rearm = 1'b0;
        chk("t5_rearm", state, 1);
        chk("t5_done_clr", done, 0);
        run_cap(4, 2, 0, -1, -1);
        chk("t5_done", done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
